// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Control bundle helpers give the canonical output patterns per situation.
package hazard_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALT     = 3'd3
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MEM_TIMEOUT_DEF  = 16;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic ifidFlush;
    logic idexEn;
    logic idexFlush;
    logic exmemEn;
    logic exmemFlush;
    logic memwbBubble;
  } hz_ctrl_t;

  function automatic hz_ctrl_t ctrlRun();
    hz_ctrl_t c;
    c = '0;
    c.pcEn = 1'b1;
    c.ifidEn = 1'b1;
    c.idexEn = 1'b1;
    c.exmemEn = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrlFreeze();
    hz_ctrl_t c;
    c = '0;
    c.memwbBubble = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrlReset();
    hz_ctrl_t c;
    c = '0;
    c.ifidFlush = 1'b1;
    c.idexFlush = 1'b1;
    c.exmemFlush = 1'b1;
    c.memwbBubble = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrlBranch();
    hz_ctrl_t c;
    c = ctrlRun();
    c.ifidFlush = 1'b1;
    c.idexFlush = 1'b1;
    c.exmemFlush = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrlHalt();
    hz_ctrl_t c;
    c = '0;
    c.ifidFlush = 1'b1;
    c.memwbBubble = 1'b1;
    return c;
  endfunction

  // The halting instruction itself still enters EX on the first cycle.
  function automatic hz_ctrl_t ctrlDrain(input logic first);
    hz_ctrl_t c;
    c = ctrlRun();
    c.pcEn = 1'b0;
    c.ifidFlush = 1'b1;
    c.idexFlush = ~first;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX feeding a source of the ID instruction.
// r0 is hardwired to zero and never creates a dependency.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       exMemRead,
  input  logic [4:0] exRd,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       idUsesRs2,
  output logic       hazard
);

  assign hazard = exMemRead
    && (exRd != REG_ZERO)
    && ((exRd == idRs1)
      || (idUsesRs2 && (exRd == idRs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer driving PC and pipeline-buffer enables/flushes.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  hz_state_t curState, nxtState;
  logic [TW-1:0] tmoCnt, nxtTmo;
  logic [DW-1:0] drainCnt, nxtDrain;
  logic fromDrain, nxtFromDrain;
  logic memErr, nxtErr;
  hz_ctrl_t ctrl, ctrlOut;

  logic luHazard;
  logic memWait;
  logic drainLast;
  logic tmoLast;
  logic doWait, doBr, doHalt, doLu;

  load_use_detect uLud (
    .exMemRead (ex_mem_read),
    .exRd      (ex_rd),
    .idRs1     (id_rs1),
    .idRs2     (id_rs2),
    .idUsesRs2 (id_uses_rs2),
    .hazard    (luHazard)
  );

  assign memWait   = mem_access & ~mem_ready;
  assign drainLast = drainCnt >= DW'(DRAIN_CYCLES - 1);
  assign tmoLast   = tmoCnt >= TW'(MEM_TIMEOUT - 1);

  assign doWait = memWait;
  assign doBr   = mem_branch_taken & ~memWait;
  assign doHalt = halt_req & ~mem_branch_taken & ~memWait;
  assign doLu   = luHazard & ~halt_req
                & ~mem_branch_taken & ~memWait;

  // Next-state, counter updates and per-state control pattern.
  always_comb begin
    nxtState     = curState;
    nxtTmo       = tmoCnt;
    nxtDrain     = drainCnt;
    nxtFromDrain = fromDrain;
    nxtErr       = memErr;
    ctrl         = ctrlRun();
    unique case (curState)
      RUN: begin
        unique case (1'b1)
          doWait: begin
            ctrl = ctrlFreeze();
            nxtState = MEM_WAIT;
            nxtTmo = TW'(1);
            nxtFromDrain = 1'b0;
          end
          doBr: ctrl = ctrlBranch();
          doHalt: begin
            nxtState = DRAIN;
            nxtDrain = '0;
          end
          doLu: begin
            ctrl.pcEn = 1'b0;
            ctrl.ifidEn = 1'b0;
            ctrl.idexFlush = 1'b1;
          end
          default: ;
        endcase
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl = ctrlFreeze();
          if (tmoLast) begin
            nxtErr = 1'b1;
            nxtState = HALT;
          end else begin
            nxtTmo = tmoCnt + 1'b1;
          end
        end else if (fromDrain) begin
          ctrl = ctrlDrain(drainCnt == '0);
          nxtDrain = drainCnt + 1'b1;
          nxtState = drainLast ? HALT : DRAIN;
        end else begin
          ctrl = ctrlRun();
          nxtState = RUN;
        end
      end
      DRAIN: begin
        if (memWait) begin
          ctrl = ctrlFreeze();
          nxtState = MEM_WAIT;
          nxtTmo = TW'(1);
          nxtFromDrain = 1'b1;
        end else if (mem_branch_taken) begin
          ctrl = ctrlBranch();
          nxtState = RUN;
        end else begin
          ctrl = ctrlDrain(drainCnt == '0);
          nxtDrain = drainCnt + 1'b1;
          nxtState = drainLast ? HALT : DRAIN;
        end
      end
      HALT: ctrl = ctrlHalt();
      default: begin
        ctrl = ctrlHalt();
        nxtState = HALT;
      end
    endcase
  end

  // Sequencer state, drain/timeout counters and sticky error.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      curState  <= RUN;
      tmoCnt    <= '0;
      drainCnt  <= '0;
      fromDrain <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      curState  <= nxtState;
      tmoCnt    <= nxtTmo;
      drainCnt  <= nxtDrain;
      fromDrain <= nxtFromDrain;
      memErr    <= nxtErr;
    end
  end

  assign ctrlOut = rst ? ctrl : ctrlReset();

  assign pc_en        = ctrlOut.pcEn;
  assign ifid_en      = ctrlOut.ifidEn;
  assign ifid_flush   = ctrlOut.ifidFlush;
  assign idex_en      = ctrlOut.idexEn;
  assign idex_flush   = ctrlOut.idexFlush;
  assign exmem_en     = ctrlOut.exmemEn;
  assign exmem_flush  = ctrlOut.exmemFlush;
  assign memwb_bubble = ctrlOut.memwbBubble;

  assign state   = curState;
  assign halted  = curState == HALT;
  assign mem_err = memErr;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  // Stall cycles outside HALT and taken-branch flushes; wrap silently.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!ctrl.pcEn && curState != HALT)
        stallCnt <= stallCnt + 1'b1;
      if (ctrl.exmemFlush)
        flushCnt <= flushCnt + 1'b1;
    end
  end

  assign stall_count = stallCnt;
  assign flush_count = flushCnt;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Inputs change and outputs are sampled just after the falling edge.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [7:0] C_RUN    = 8'hD4;
  localparam logic [7:0] C_RESET  = 8'h2B;
  localparam logic [7:0] C_FREEZE = 8'h01;
  localparam logic [7:0] C_BRANCH = 8'hFE;
  localparam logic [7:0] C_LU     = 8'h1C;
  localparam logic [7:0] C_HALT   = 8'h21;
  localparam logic [7:0] C_DRN0   = 8'h74;
  localparam logic [7:0] C_DRN    = 8'h7C;

  logic clk_div = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs2, ex_mem_read, mem_branch_taken;
  logic mem_access, mem_ready, halt_req;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_bubble;
  logic [2:0] state;
  logic halted, mem_err;
  logic [31:0] stall_count, flush_count;
  logic [7:0] ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_en, exmem_flush, memwb_bubble};

  always #5 clk_div = ~clk_div;

  pipeline_hazard_ctrl dut (
    .clk_div(clk_div), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble),
    .state(state), .halted(halted), .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic clearIn();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs2 = 0; ex_mem_read = 0;
    mem_branch_taken = 0; mem_access = 0;
    mem_ready = 0; halt_req = 0;
  endtask

  task automatic resetDut();
    clearIn();
    rst = 1'b0;
    @(negedge clk_div);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clearIn();
    rst = 1'b0;
    #3;
    checks++;
    if (ctl !== C_RESET) begin
      errors++;
      $display("FAIL reset_ctl: got %h want %h", ctl, C_RESET);
    end
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d h=%b e=%b want 0 0 0",
               state, halted, mem_err);
    end
    checks++;
    if (stall_count !== 0 || flush_count !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0",
               stall_count, flush_count);
    end
    @(negedge clk_div);
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL run_default: got %h want %h", ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    resetDut();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++;
      $display("FAIL lu_stall: got %h want %h", ctl, C_LU);
    end
    @(negedge clk_div);
    ex_mem_read = 0;
    #1;
    checks++;
    if (ctl !== C_RUN || state !== 3'd0) begin
      errors++;
      $display("FAIL lu_after: got %h st=%0d want %h st=0",
               ctl, state, C_RUN);
    end
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL lu_r0: got %h want %h", ctl, C_RUN);
    end
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL lu_rs2_unused: got %h want %h", ctl, C_RUN);
    end
    id_uses_rs2 = 1;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++;
      $display("FAIL lu_rs2: got %h want %h", ctl, C_LU);
    end
    clearIn();
  endtask

  task automatic test_branch();
    resetDut();
    mem_branch_taken = 1; halt_req = 1;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++;
      $display("FAIL br_flush: got %h want %h", ctl, C_BRANCH);
    end
    @(negedge clk_div);
    clearIn();
    #1;
    checks++;
    if (ctl !== C_RUN || state !== 3'd0) begin
      errors++;
      $display("FAIL br_after: got %h st=%0d want %h st=0",
               ctl, state, C_RUN);
    end
    checks++;
    if (flush_count !== 32'(PERF)) begin
      errors++;
      $display("FAIL br_count: got %0d want %0d", flush_count, PERF);
    end
  endtask

  task automatic test_mem_wait();
    resetDut();
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE || state !== (i == 0 ? 3'd0 : 3'd1)) begin
        errors++;
        $display("FAIL mw_freeze%0d: got %h st=%0d want %h", i,
                 ctl, state, C_FREEZE);
      end
      @(negedge clk_div);
    end
    mem_ready = 1;
    #1;
    checks++;
    if (ctl !== C_RUN || state !== 3'd1) begin
      errors++;
      $display("FAIL mw_ready: got %h st=%0d want %h st=1",
               ctl, state, C_RUN);
    end
    @(negedge clk_div);
    clearIn();
    #1;
    checks++;
    if (state !== 3'd0 || stall_count !== 32'(4 * PERF)) begin
      errors++;
      $display("FAIL mw_resume: got st=%0d stalls=%0d want 0 %0d",
               state, stall_count, 4 * PERF);
    end
  endtask

  task automatic test_timeout();
    resetDut();
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (state !== (i == 0 ? 3'd0 : 3'd1) || mem_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d: got st=%0d e=%b", i, state, mem_err);
      end
      @(negedge clk_div);
    end
    #1;
    checks++;
    if (state !== 3'd3 || halted !== 1'b1 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL to_halt: got st=%0d h=%b e=%b want 3 1 1",
               state, halted, mem_err);
    end
    clearIn();
    mem_ready = 1;
    repeat (3) @(negedge clk_div);
    #1;
    checks++;
    if (state !== 3'd3 || mem_err !== 1'b1 || ctl !== C_HALT) begin
      errors++;
      $display("FAIL to_stay: got st=%0d e=%b ctl=%h want 3 1 %h",
               state, mem_err, ctl, C_HALT);
    end
    checks++;
    if (stall_count !== 32'(16 * PERF)) begin
      errors++;
      $display("FAIL to_stalls: got %0d want %0d",
               stall_count, 16 * PERF);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_err !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got st=%0d e=%b h=%b want 0 0 0",
               state, mem_err, halted);
    end
    @(negedge clk_div);
    rst = 1'b1;
  endtask

  task automatic test_drain();
    resetDut();
    halt_req = 1;
    #1;
    checks++;
    if (ctl !== C_RUN || state !== 3'd0) begin
      errors++;
      $display("FAIL dr_req: got %h st=%0d want %h", ctl, state, C_RUN);
    end
    @(negedge clk_div);
    halt_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 3'd2 || ctl !== (i == 0 ? C_DRN0 : C_DRN)) begin
        errors++;
        $display("FAIL dr_cyc%0d: got st=%0d ctl=%h", i, state, ctl);
      end
      @(negedge clk_div);
    end
    #1;
    checks++;
    if (state !== 3'd3 || halted !== 1'b1 || ctl !== C_HALT) begin
      errors++;
      $display("FAIL dr_halt: got st=%0d h=%b ctl=%h want 3 1 %h",
               state, halted, ctl, C_HALT);
    end
    resetDut();
    halt_req = 1;
    @(negedge clk_div);
    halt_req = 0;
    mem_branch_taken = 1;
    #1;
    checks++;
    if (state !== 3'd2 || ctl !== C_BRANCH) begin
      errors++;
      $display("FAIL dr_abort: got st=%0d ctl=%h want 2 %h",
               state, ctl, C_BRANCH);
    end
    @(negedge clk_div);
    clearIn();
    repeat (3) @(negedge clk_div);
    #1;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || ctl !== C_RUN) begin
      errors++;
      $display("FAIL dr_resume: got st=%0d h=%b ctl=%h want 0 0 %h",
               state, halted, ctl, C_RUN);
    end
  endtask

  task automatic test_async_reset();
    resetDut();
    mem_access = 1; mem_ready = 0;
    repeat (3) @(negedge clk_div);
    #1;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL ar_pre: got st=%0d want 1", state);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_err !== 1'b0 || ctl !== C_RESET) begin
      errors++;
      $display("FAIL ar_now: got st=%0d e=%b ctl=%h want 0 0 %h",
               state, mem_err, ctl, C_RESET);
    end
    checks++;
    if (stall_count !== 0 || flush_count !== 0) begin
      errors++;
      $display("FAIL ar_cnt: got %0d/%0d want 0/0",
               stall_count, flush_count);
    end
    clearIn();
    @(negedge clk_div);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    clearIn();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_drain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
